// File: rtl/contador_fsm_checker.sv
// Receive-side lock/order checker for the scrambled 3-bit count 0,3,4,2,5,7,6,1.
// Reports sequence position, lock status, order-violation pulses and a saturating error count.
module contador_fsm_checker #(
  parameter int LOCK_CNT   = 3,
  parameter int UNLOCK_CNT = 2,
  parameter int ERR_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [2:0]       d,
  output logic [2:0]       idx,
  output logic             locked,
  output logic             err,
  output logic [ERR_W-1:0] err_count,
  output logic [1:0]       state_o
);

  localparam logic [1:0] ST_SEARCH  = 2'd0;
  localparam logic [1:0] ST_ACQUIRE = 2'd1;
  localparam logic [1:0] ST_LOCKED  = 2'd2;
  localparam logic [1:0] ST_SLIP    = 2'd3;

  localparam int GW = $clog2(LOCK_CNT + 1);
  localparam int BW = $clog2(UNLOCK_CNT + 1);
  localparam logic [GW-1:0]    LOCK_V   = GW'(LOCK_CNT);
  localparam logic [BW-1:0]    UNLOCK_V = BW'(UNLOCK_CNT);
  localparam logic [ERR_W-1:0] CNT_MAX  = {ERR_W{1'b1}};

  function automatic logic [2:0] succ_f(input logic [2:0] v);
    logic [2:0] r;
    case (v)
      3'd0:    r = 3'd3;
      3'd3:    r = 3'd4;
      3'd4:    r = 3'd2;
      3'd2:    r = 3'd5;
      3'd5:    r = 3'd7;
      3'd7:    r = 3'd6;
      3'd6:    r = 3'd1;
      3'd1:    r = 3'd0;
      default: r = 3'd0;
    endcase
    return r;
  endfunction

  function automatic logic [2:0] index_f(input logic [2:0] v);
    logic [2:0] r;
    case (v)
      3'd0:    r = 3'd0;
      3'd3:    r = 3'd1;
      3'd4:    r = 3'd2;
      3'd2:    r = 3'd3;
      3'd5:    r = 3'd4;
      3'd7:    r = 3'd5;
      3'd6:    r = 3'd6;
      3'd1:    r = 3'd7;
      default: r = 3'd0;
    endcase
    return r;
  endfunction

  logic [1:0]       state_q, state_d;
  logic [2:0]       idx_q, idx_d;
  logic             locked_q, locked_d;
  logic             err_q, err_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
  logic [2:0]       exp_q, exp_d;
  logic [GW-1:0]    good_q, good_d;
  logic [BW-1:0]    bad_q, bad_d;
  logic             match_s;
  logic [GW-1:0]    good_inc_s;
  logic [BW-1:0]    bad_inc_s;

  assign match_s    = (d == exp_q);
  assign good_inc_s = good_q + GW'(1);
  assign bad_inc_s  = bad_q + BW'(1);

  // Next-state logic: FSM advances only on qualified samples.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    exp_d     = exp_q;
    good_d    = good_q;
    bad_d     = bad_q;
    err_d     = 1'b0;
    err_cnt_d = err_cnt_q;
    if (in_valid) begin
      idx_d = index_f(d);
      case (state_q)
        ST_SEARCH: begin
          exp_d   = succ_f(d);
          good_d  = GW'(1);
          state_d = ST_ACQUIRE;
        end
        ST_ACQUIRE: begin
          exp_d = succ_f(d);
          if (match_s) begin
            good_d = good_inc_s;
            if (good_inc_s == LOCK_V) begin
              state_d = ST_LOCKED;
            end else begin
              state_d = ST_ACQUIRE;
            end
          end else begin
            good_d = GW'(1);
          end
        end
        ST_LOCKED: begin
          if (match_s) begin
            exp_d = succ_f(d);
          end else begin
            // Flywheel: keep counting from the expected symbol, ignore the bad one.
            err_d = 1'b1;
            exp_d = succ_f(exp_q);
            if (UNLOCK_CNT == 1) begin
              state_d = ST_SEARCH;
              good_d  = GW'(0);
              bad_d   = BW'(0);
            end else begin
              state_d = ST_SLIP;
              bad_d   = BW'(1);
            end
          end
        end
        ST_SLIP: begin
          if (match_s) begin
            bad_d   = BW'(0);
            exp_d   = succ_f(d);
            state_d = ST_LOCKED;
          end else begin
            err_d = 1'b1;
            exp_d = succ_f(exp_q);
            if (bad_inc_s == UNLOCK_V) begin
              state_d = ST_SEARCH;
              good_d  = GW'(0);
              bad_d   = BW'(0);
            end else begin
              bad_d = bad_inc_s;
            end
          end
        end
        default: begin
          state_d = ST_SEARCH;
          good_d  = GW'(0);
          bad_d   = BW'(0);
        end
      endcase
    end else begin
      err_d = 1'b0;
    end
    if (err_d && (err_cnt_q != CNT_MAX)) begin
      err_cnt_d = err_cnt_q + ERR_W'(1);
    end else begin
      err_cnt_d = err_cnt_q;
    end
    locked_d = (state_d == ST_LOCKED) || (state_d == ST_SLIP);
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_SEARCH;
      idx_q     <= 3'd0;
      locked_q  <= 1'b0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
      exp_q     <= 3'd0;
      good_q    <= '0;
      bad_q     <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      locked_q  <= locked_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
      exp_q     <= exp_d;
      good_q    <= good_d;
      bad_q     <= bad_d;
    end
  end

  assign idx       = idx_q;
  assign locked    = locked_q;
  assign err       = err_q;
  assign err_count = err_cnt_q;
  assign state_o   = state_q;

endmodule

// File: tb/tb_contador_fsm_checker.sv
// Scoreboard bench: a position-based reference model pushes expectations per sample,
// which are popped and compared one cycle later against an ERR_W=8 and an ERR_W=2 instance.
module tb_contador_fsm_checker;

  localparam int LOCK_CNT   = 3;
  localparam int UNLOCK_CNT = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [2:0] d = 3'd0;

  logic [2:0] idx8, idx2;
  logic       locked8, locked2, err8, err2;
  logic [7:0] cnt8;
  logic [1:0] cnt2;
  logic [1:0] st8, st2;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [2:0] idx;
    logic       locked;
    logic       err;
    logic [7:0] cnt8;
    logic [1:0] cnt2;
    logic [1:0] state;
  } exp_t;

  exp_t sbq[$];

  logic [2:0] seq_tab [8] = '{3'd0, 3'd3, 3'd4, 3'd2, 3'd5, 3'd7, 3'd6, 3'd1};

  // reference model state (positions in the sequence, not symbols)
  int m_state, m_exp, m_good, m_bad, m_idx, m_cnt8, m_cnt2;
  bit m_err;

  contador_fsm_checker #(.LOCK_CNT(LOCK_CNT), .UNLOCK_CNT(UNLOCK_CNT), .ERR_W(8)) dut8 (
    .clk(clk), .rst(rst_n), .in_valid(in_valid), .d(d),
    .idx(idx8), .locked(locked8), .err(err8), .err_count(cnt8), .state_o(st8));

  contador_fsm_checker #(.LOCK_CNT(LOCK_CNT), .UNLOCK_CNT(UNLOCK_CNT), .ERR_W(2)) dut2 (
    .clk(clk), .rst(rst_n), .in_valid(in_valid), .d(d),
    .idx(idx2), .locked(locked2), .err(err2), .err_count(cnt2), .state_o(st2));

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_checks++;
    if (obs !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, want, $time);
    end
  endtask

  function automatic int pos_of(input logic [2:0] v);
    for (int i = 0; i < 8; i++) begin
      if (seq_tab[i] == v) return i;
    end
    return 0;
  endfunction

  task automatic model_reset();
    m_state = 0; m_exp = 0; m_good = 0; m_bad = 0;
    m_idx = 0; m_cnt8 = 0; m_cnt2 = 0; m_err = 1'b0;
  endtask

  task automatic model_step(input logic v, input logic [2:0] dv);
    int ix;
    m_err = 1'b0;
    if (v) begin
      ix = pos_of(dv);
      m_idx = ix;
      case (m_state)
        0: begin m_exp = (ix + 1) % 8; m_good = 1; m_state = 1; end
        1: begin
          if (ix == m_exp) begin
            m_good++;
            if (m_good == LOCK_CNT) m_state = 2;
          end else begin
            m_good = 1;
          end
          m_exp = (ix + 1) % 8;
        end
        2: begin
          if (ix == m_exp) m_exp = (ix + 1) % 8;
          else begin m_err = 1'b1; m_exp = (m_exp + 1) % 8; m_bad = 1; m_state = 3; end
        end
        default: begin
          if (ix == m_exp) begin m_bad = 0; m_exp = (ix + 1) % 8; m_state = 2; end
          else begin
            m_err = 1'b1; m_exp = (m_exp + 1) % 8; m_bad++;
            if (m_bad == UNLOCK_CNT) begin m_state = 0; m_good = 0; m_bad = 0; end
          end
        end
      endcase
      if (m_err) begin
        if (m_cnt8 < 255) m_cnt8++;
        if (m_cnt2 < 3) m_cnt2++;
      end
    end
  endtask

  task automatic compare_out();
    exp_t e;
    if (sbq.size() == 0) begin
      check_eq("sb_empty", 32'd1, 32'd0);
    end else begin
      e = sbq.pop_front();
      check_eq("idx", {29'd0, idx8}, {29'd0, e.idx});
      check_eq("locked", {31'd0, locked8}, {31'd0, e.locked});
      check_eq("err", {31'd0, err8}, {31'd0, e.err});
      check_eq("err_count8", {24'd0, cnt8}, {24'd0, e.cnt8});
      check_eq("state", {30'd0, st8}, {30'd0, e.state});
      check_eq("err_count2", {30'd0, cnt2}, {30'd0, e.cnt2});
      check_eq("locked_w2", {31'd0, locked2}, {31'd0, e.locked});
      check_eq("idx_w2", {29'd0, idx2}, {29'd0, e.idx});
      check_eq("err_w2", {31'd0, err2}, {31'd0, e.err});
      check_eq("state_w2", {30'd0, st2}, {30'd0, e.state});
    end
  endtask

  task automatic drive(input logic v, input logic [2:0] dv);
    exp_t e;
    @(negedge clk);
    in_valid = v;
    d = dv;
    model_step(v, dv);
    e.idx    = 3'(m_idx);
    e.locked = (m_state >= 2);
    e.err    = m_err;
    e.cnt8   = 8'(m_cnt8);
    e.cnt2   = 2'(m_cnt2);
    e.state  = 2'(m_state);
    sbq.push_back(e);
    @(posedge clk);
    #1;
    compare_out();
  endtask

  task automatic send_good();
    drive(1'b1, seq_tab[m_exp]);
  endtask

  task automatic send_bad();
    drive(1'b1, seq_tab[(m_exp + 4) % 8]);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_idx"}, {29'd0, idx8}, 32'd0);
    check_eq({tag, "_locked"}, {31'd0, locked8}, 32'd0);
    check_eq({tag, "_err"}, {31'd0, err8}, 32'd0);
    check_eq({tag, "_cnt8"}, {24'd0, cnt8}, 32'd0);
    check_eq({tag, "_cnt2"}, {30'd0, cnt2}, 32'd0);
    check_eq({tag, "_state"}, {30'd0, st8}, 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    in_valid = 1'b0;
    model_reset();
    sbq.delete();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic [2:0] stream1 [10] = '{3'd0, 3'd3, 3'd4, 3'd2, 3'd5, 3'd7, 3'd6, 3'd1, 3'd0, 3'd3};
  logic [2:0] slip1 [6]    = '{3'd4, 3'd2, 3'd0, 3'd7, 3'd6, 3'd1};
  logic [2:0] unlock1 [8]  = '{3'd0, 3'd3, 3'd4, 3'd0, 3'd0, 3'd5, 3'd7, 3'd6};

  initial begin
    model_reset();
    #12;
    check_all_zero("reset");
    do_reset();

    // aligned stream, lock after third sample, wrap 1->0
    foreach (stream1[i]) drive(1'b1, stream1[i]);
    check_eq("lock_after_stream", {31'd0, locked8}, 32'd1);
    // single bad symbol replacing 5
    foreach (slip1[i]) drive(1'b1, slip1[i]);
    check_eq("slip_cnt", {24'd0, cnt8}, 32'd1);
    // two consecutive bad symbols, then re-lock on 5,7,6
    foreach (unlock1[i]) drive(1'b1, unlock1[i]);
    check_eq("relock_cnt", {24'd0, cnt8}, 32'd3);

    // seed mid-sequence from reset
    do_reset();
    drive(1'b1, 3'd5); drive(1'b1, 3'd7); drive(1'b1, 3'd6); drive(1'b1, 3'd1);

    // gaps between samples
    do_reset();
    drive(1'b1, 3'd0);
    for (int i = 0; i < 5; i++) drive(1'b0, 3'($urandom_range(7)));
    drive(1'b1, 3'd3);
    drive(1'b1, 3'd4);
    check_eq("gap_lock", {31'd0, locked8}, 32'd1);

    // saturation of the narrow counter
    do_reset();
    drive(1'b1, 3'd0); drive(1'b1, 3'd3); drive(1'b1, 3'd4);
    for (int k = 0; k < 5; k++) begin
      send_bad();
      send_good();
      send_good();
    end
    check_eq("sat_cnt2", {30'd0, cnt2}, 32'd3);
    check_eq("sat_cnt8", {24'd0, cnt8}, 32'd5);

    // random mix of good, bad and idle samples
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(3))
        0:       drive(1'b0, 3'($urandom_range(7)));
        1:       drive(1'b1, 3'($urandom_range(7)));
        default: send_good();
      endcase
    end

    // asynchronous reset mid-stream, checked before the next clock edge
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    model_reset();
    sbq.delete();
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 3'd2);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
